// File: rtl/midi_pkg.sv
// Shared MIDI writer types, status-nibble constants and message-length rule.
`timescale 1ns/1ps
package midi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SEND_STATUS = 2'd1,
    ST_SEND_D1     = 2'd2,
    ST_SEND_D2     = 2'd3
  } midi_state_e;

  localparam logic [3:0] NOTE_OFF         = 4'h8;
  localparam logic [3:0] NOTE_ON          = 4'h9;
  localparam logic [3:0] POLY_PRESSURE    = 4'hA;
  localparam logic [3:0] CONTROL_CHANGE   = 4'hB;
  localparam logic [3:0] PROGRAM_CHANGE   = 4'hC;
  localparam logic [3:0] CHANNEL_PRESSURE = 4'hD;
  localparam logic [3:0] PITCH_BEND       = 4'hE;
  localparam logic [3:0] SYSTEM           = 4'hF;

  // Total bytes on the wire for a status nibble; 0 marks an invalid message.
  function automatic logic [1:0] msg_len(input logic [3:0] status);
    logic [1:0] len;
    if (status < NOTE_OFF) begin
      len = 2'd0;
    end else if (status == SYSTEM) begin
      len = 2'd1;
    end else if (status == PROGRAM_CHANGE || status == CHANNEL_PRESSURE) begin
      len = 2'd2;
    end else begin
      len = 2'd3;
    end
    return len;
  endfunction

endpackage

// File: rtl/uart_transmit.sv
// 8N1 serialiser. busy_out drops during the last cycle of the stop bit so a
// byte triggered then starts on the very next edge with no idle gap.
`timescale 1ns/1ps
module uart_transmit #(
  parameter int unsigned CLKS_PER_BIT = 3200  // must be >= 2
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] data_byte_in,
  input  logic       trigger_in,
  output logic       busy_out,
  output logic       tx_wire_out
);

  localparam int unsigned CYC_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CYC_W-1:0] LAST_CYC   = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [CYC_W-1:0] PENULT_CYC = CYC_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]       STOP_IDX   = 4'd9;

  logic [8:0]       frame_q;  // remaining data bits then stop bit, LSB next
  logic [3:0]       bit_q;    // 0 = start, 1..8 = data, 9 = stop
  logic [CYC_W-1:0] cyc_q;
  logic             active_q;
  logic             busy_q;
  logic             tx_q;

  // Bit timing, shifting and handshake.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_q  <= '1;
      bit_q    <= '0;
      cyc_q    <= '0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      tx_q     <= 1'b1;
    end else if (trigger_in && !busy_q) begin
      frame_q  <= {1'b1, data_byte_in};
      bit_q    <= '0;
      cyc_q    <= '0;
      active_q <= 1'b1;
      busy_q   <= 1'b1;
      tx_q     <= 1'b0;
    end else if (active_q) begin
      if (cyc_q == LAST_CYC) begin
        cyc_q <= '0;
        if (bit_q == STOP_IDX) begin
          active_q <= 1'b0;
          tx_q     <= 1'b1;
        end else begin
          bit_q   <= bit_q + 4'd1;
          frame_q <= {1'b1, frame_q[8:1]};
          tx_q    <= frame_q[0];
        end
      end else begin
        cyc_q <= cyc_q + CYC_W'(1);
      end
      if (bit_q == STOP_IDX && cyc_q == PENULT_CYC) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy_out    = busy_q;
  assign tx_wire_out = tx_q;

endmodule

// File: rtl/midi_writer.sv
// MIDI message writer: validates, applies running status, and streams the
// status/data bytes through one UART serialiser.
`timescale 1ns/1ps
module midi_writer
  import midi_pkg::*;
#(
  parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE        = 31250,
  parameter int unsigned RUNNING_STATUS   = 1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [3:0] status_in,
  input  logic [3:0] channel_in,
  input  logic [7:0] data_byte1_in,
  input  logic [7:0] data_byte2_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_wire_out,
  output logic       err_out
);

  localparam int unsigned CLKS_PER_BIT = INPUT_CLOCK_FREQ / BAUD_RATE;

  midi_state_e state_q;
  midi_state_e next_state_c;
  logic [7:0]  status_q, d1_q, d2_q;
  logic [1:0]  len_q;
  logic        arm_q;       // one-cycle delay between acceptance and first trigger
  logic        launched_q;  // current state's byte already handed to the UART
  logic [7:0]  rs_q;
  logic        rs_valid_q;
  logic        ready_q, err_q;

  logic [7:0]  cur_byte_c, next_byte_c, tx_byte_c;
  logic        has_next_c, trig_c, handoff_c, frame_done_c;
  logic        accept_c, is_channel_c, skip_c, uart_busy;
  logic [1:0]  len_c;

  // Byte selection and successor state for the byte currently on the line.
  always_comb begin
    cur_byte_c   = status_q;
    next_byte_c  = d2_q;
    has_next_c   = 1'b0;
    next_state_c = ST_IDLE;
    unique case (state_q)
      ST_SEND_STATUS: begin
        next_byte_c  = d1_q;
        has_next_c   = (len_q >= 2'd2);
        next_state_c = has_next_c ? ST_SEND_D1 : ST_IDLE;
      end
      ST_SEND_D1: begin
        cur_byte_c   = d1_q;
        has_next_c   = (len_q == 2'd3);
        next_state_c = has_next_c ? ST_SEND_D2 : ST_IDLE;
      end
      ST_SEND_D2: cur_byte_c = d2_q;
      default: ;
    endcase
  end

  assign accept_c     = valid_in && ready_q;
  assign len_c        = msg_len(status_in);
  assign is_channel_c = (status_in >= NOTE_OFF) && (status_in != SYSTEM);
  assign skip_c       = (RUNNING_STATUS != 0) && is_channel_c && rs_valid_q &&
                        (rs_q == {status_in, channel_in});
  // Trigger the first byte, then pre-offer the next one so it follows gaplessly.
  assign trig_c       = (state_q != ST_IDLE) && !arm_q && (!launched_q || has_next_c);
  assign tx_byte_c    = launched_q ? next_byte_c : cur_byte_c;
  assign handoff_c    = trig_c && !uart_busy;
  assign frame_done_c = (state_q != ST_IDLE) && launched_q && !uart_busy;

  // Message sequencing, handshake outputs and running-status tracking.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      status_q   <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      len_q      <= '0;
      arm_q      <= 1'b0;
      launched_q <= 1'b0;
      rs_q       <= '0;
      rs_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        ready_q <= 1'b1;
        if (accept_c) begin
          ready_q    <= 1'b0;
          status_q   <= {status_in, channel_in};
          d1_q       <= data_byte1_in & 8'h7F;
          d2_q       <= data_byte2_in & 8'h7F;
          len_q      <= len_c;
          arm_q      <= 1'b1;
          launched_q <= 1'b0;
          if (len_c == 2'd0) begin
            err_q <= 1'b1;
          end else if (skip_c) begin
            state_q <= ST_SEND_D1;
          end else begin
            state_q <= ST_SEND_STATUS;
          end
        end
      end else begin
        arm_q <= 1'b0;
        if (handoff_c) begin
          launched_q <= 1'b1;
        end
        if (frame_done_c) begin
          state_q    <= next_state_c;
          launched_q <= has_next_c;
          if (!has_next_c) begin
            ready_q <= 1'b1;
          end
        end
      end
      if (handoff_c && tx_byte_c[7]) begin
        if (tx_byte_c[7:4] != SYSTEM) begin
          rs_q       <= tx_byte_c;
          rs_valid_q <= 1'b1;
        end else if (!tx_byte_c[3]) begin
          rs_valid_q <= 1'b0;
        end
      end
    end
  end

  uart_transmit #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .data_byte_in (tx_byte_c),
    .trigger_in   (handoff_c),
    .busy_out     (uart_busy),
    .tx_wire_out  (tx_wire_out)
  );

  assign ready_out = ready_q;
  assign err_out   = err_q;

endmodule

// File: tb/tb_midi_writer.sv
// Bench for midi_writer: one instance with running status, one without,
// both decoded from their serial lines and checked against a message model.
`timescale 1ns/1ps
module tb_midi_writer;

  localparam int B     = 8;       // clocks per bit for this bench
  localparam int FRAME = 10 * B;

  logic       clk;
  logic       rst_n;
  logic [3:0] status, chan;
  logic [7:0] d1, d2;
  logic       valid;
  logic       ready_a, tx_a, err_a;
  logic       ready_b, tx_b, err_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rst_cnt = 0;

  logic [7:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
  int         st_a[$], st_b[$];
  logic       m_rsv [2];
  logic [7:0] m_rs  [2];

  typedef struct {
    logic [3:0]  s;
    logic [3:0]  c;
    logic [7:0]  a;
    logic [7:0]  d;
    int          n;      // expected byte count with running status on
    logic [23:0] bytes;  // expected bytes, first in the top octet
  } vec_t;
  vec_t tbl[13];

  midi_writer #(.INPUT_CLOCK_FREQ(800), .BAUD_RATE(100), .RUNNING_STATUS(1)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .status_in(status), .channel_in(chan),
    .data_byte1_in(d1), .data_byte2_in(d2), .valid_in(valid),
    .ready_out(ready_a), .tx_wire_out(tx_a), .err_out(err_a));

  midi_writer #(.INPUT_CLOCK_FREQ(800), .BAUD_RATE(100), .RUNNING_STATUS(0)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .status_in(status), .channel_in(chan),
    .data_byte1_in(d1), .data_byte2_in(d2), .valid_in(valid),
    .ready_out(ready_b), .tx_wire_out(tx_b), .err_out(err_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_cnt = rst_cnt + 1;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic line(input int which);
    return (which == 0) ? tx_a : tx_b;
  endfunction

  // UART receiver: mid-bit sampling, frames cut by reset are dropped.
  task automatic decode(input int which);
    logic [7:0] b;
    logic       lv;
    int         s, r0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && line(which) === 1'b0) begin
        s  = cyc;
        r0 = rst_cnt;
        repeat (B / 2) @(negedge clk);
        lv = line(which);
        if (rst_cnt == r0) chk("start_bit", int'(lv), 0);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = line(which);
        end
        repeat (B) @(negedge clk);
        lv = line(which);
        if (rst_cnt == r0) begin
          chk("stop_bit", int'(lv), 1);
          if (which == 0) begin got_a.push_back(b); st_a.push_back(s); end
          else begin got_b.push_back(b); st_b.push_back(s); end
        end
        repeat (B / 2 - 1) @(negedge clk);
      end
    end
  endtask

  initial decode(0);
  initial decode(1);

  // Message rules: length by status, 7-bit data, running-status omission.
  task automatic model_msg(input int which, input logic [3:0] s, input logic [3:0] c,
                           input logic [7:0] a, input logic [7:0] d);
    logic [7:0] m[$];
    logic [7:0] sb;
    sb = {s, c};
    m  = {};
    if (s < 4'h8) return;
    m.push_back(sb);
    if (s != 4'hF) m.push_back(a & 8'h7F);
    if (s != 4'hF && s != 4'hC && s != 4'hD) m.push_back(d & 8'h7F);
    if (which == 0 && s != 4'hF && m_rsv[which] && m_rs[which] == sb) void'(m.pop_front());
    foreach (m[i]) begin
      if (m[i] >= 8'h80 && m[i] < 8'hF0) begin
        m_rs[which]  = m[i];
        m_rsv[which] = 1'b1;
      end else if (m[i] >= 8'hF0 && m[i] < 8'hF8) begin
        m_rsv[which] = 1'b0;
      end
      if (which == 0) exp_a.push_back(m[i]); else exp_b.push_back(m[i]);
    end
  endtask

  task automatic wait_ready();
    int t0;
    t0 = cyc;
    while (!(ready_a === 1'b1 && ready_b === 1'b1) && (cyc - t0) < 4 * FRAME) @(negedge clk);
    chk("ready_wait", int'(ready_a & ready_b), 1);
  endtask

  task automatic clear_q();
    got_a = {}; got_b = {}; exp_a = {}; exp_b = {}; st_a = {}; st_b = {};
  endtask

  task automatic send_msg(input logic [3:0] s, input logic [3:0] c, input logic [7:0] a,
                          input logic [7:0] d, input int n, input logic [23:0] bytes);
    int acc, ra, rb, e, na, nb;
    wait_ready();
    model_msg(0, s, c, a, d);
    model_msg(1, s, c, a, d);
    if (n >= 0) begin
      exp_a = {};
      for (int i = 0; i < n; i++) exp_a.push_back(bytes[23 - 8 * i -: 8]);
    end
    e = (s < 4'h8) ? 1 : 0;
    status = s; chan = c; d1 = a; d2 = d; valid = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    valid = 1'b0;
    status = 4'($urandom); chan = 4'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
    chk("ready_drop_a", int'(ready_a), 0);
    chk("ready_drop_b", int'(ready_b), 0);
    chk("err_a", int'(err_a), e);
    chk("err_b", int'(err_b), e);
    @(negedge clk);
    chk("err_end_a", int'(err_a), 0);
    chk("err_end_b", int'(err_b), 0);
    if (e == 0) valid = 1'b1;  // offered while busy: must be ignored
    ra = -1; rb = -1;
    forever begin
      if (cyc >= acc + 4) valid = 1'b0;
      if (ra < 0 && ready_a === 1'b1) ra = cyc;
      if (rb < 0 && ready_b === 1'b1) rb = cyc;
      if ((ra >= 0 && rb >= 0) || (cyc - acc) > 4 * FRAME) break;
      @(negedge clk);
    end
    valid = 1'b0;
    na = exp_a.size();
    nb = exp_b.size();
    chk("ready_time_a", ra, (e != 0) ? acc + 1 : acc + 2 + FRAME * na);
    chk("ready_time_b", rb, (e != 0) ? acc + 1 : acc + 2 + FRAME * nb);
    chk("nbytes_a", got_a.size(), na);
    chk("nbytes_b", got_b.size(), nb);
    for (int i = 0; i < na && i < got_a.size(); i++) begin
      chk($sformatf("byte_a[%0d]", i), int'(got_a[i]), int'(exp_a[i]));
      chk($sformatf("start_a[%0d]", i), st_a[i], acc + 2 + FRAME * i);
    end
    for (int i = 0; i < nb && i < got_b.size(); i++) begin
      chk($sformatf("byte_b[%0d]", i), int'(got_b[i]), int'(exp_b[i]));
      chk($sformatf("start_b[%0d]", i), st_b[i], acc + 2 + FRAME * i);
    end
    clear_q();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    tbl[0]  = '{4'h9, 4'h0, 8'h3C, 8'h64, 3, 24'h903C64};
    tbl[1]  = '{4'h9, 4'h0, 8'h40, 8'h00, 2, 24'h400000};
    tbl[2]  = '{4'hC, 4'h3, 8'h05, 8'h77, 2, 24'hC30500};
    tbl[3]  = '{4'hF, 4'h8, 8'h12, 8'h34, 1, 24'hF80000};
    tbl[4]  = '{4'hC, 4'h3, 8'h05, 8'h00, 1, 24'h050000};
    tbl[5]  = '{4'hB, 4'h1, 8'hFF, 8'h80, 3, 24'hB17F00};
    tbl[6]  = '{4'h5, 4'h2, 8'h11, 8'h22, 0, 24'h000000};
    tbl[7]  = '{4'hF, 4'h0, 8'h00, 8'h00, 1, 24'hF00000};
    tbl[8]  = '{4'hB, 4'h1, 8'h11, 8'h22, 3, 24'hB11122};
    tbl[9]  = '{4'hE, 4'hF, 8'hFF, 8'hFF, 3, 24'hEF7F7F};
    tbl[10] = '{4'hD, 4'h4, 8'h81, 8'h9A, 2, 24'hD40100};
    tbl[11] = '{4'hD, 4'h4, 8'h02, 8'h00, 1, 24'h020000};
    tbl[12] = '{4'h0, 4'h0, 8'h00, 8'h00, 0, 24'h000000};

    m_rsv[0] = 1'b0; m_rsv[1] = 1'b0; m_rs[0] = '0; m_rs[1] = '0;
    rst_n = 1'b0; valid = 1'b0; status = '0; chan = '0; d1 = '0; d2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_a", int'(tx_a), 1);
    chk("rst_ready_a", int'(ready_a), 0);
    chk("rst_err_a", int'(err_a), 0);
    chk("rst_tx_b", int'(tx_b), 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst_a", int'(ready_a), 1);
    chk("ready_after_rst_b", int'(ready_b), 1);

    foreach (tbl[i]) send_msg(tbl[i].s, tbl[i].c, tbl[i].a, tbl[i].d, tbl[i].n, tbl[i].bytes);

    // Reset in the middle of data bit 4 of the second byte.
    wait_ready();
    status = 4'h9; chan = 4'h2; d1 = 8'h05; d2 = 8'h33; valid = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    valid = 1'b0;
    while (cyc < acc + 2 + FRAME + 5 * B + B / 2) @(negedge clk);
    chk("bit4_a", int'(tx_a), 0);
    chk("bit4_b", int'(tx_b), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_a", int'(tx_a), 1);
    chk("midrst_tx_b", int'(tx_b), 1);
    chk("midrst_ready_a", int'(ready_a), 0);
    chk("midrst_err_a", int'(err_a), 0);
    repeat (3) @(negedge clk);
    chk("inrst_tx_a", int'(tx_a), 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midrst_a", int'(ready_a), 1);
    chk("ready_after_midrst_b", int'(ready_b), 1);
    repeat (FRAME + B) @(negedge clk);
    chk("partial_nbytes_a", got_a.size(), 1);
    if (got_a.size() > 0) chk("partial_byte_a", int'(got_a[0]), 32'h92);
    clear_q();
    m_rsv[0] = 1'b0; m_rsv[1] = 1'b0;
    send_msg(4'h9, 4'h2, 8'h10, 8'h20, 3, 24'h921020);

    for (int k = 0; k < 40; k++) begin
      send_msg(4'($urandom_range(5, 15)), 4'($urandom_range(0, 1)),
               8'($urandom), 8'($urandom), -1, 24'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
